pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised next-generation PC generator for the in-order RISC-V fetch stage.
- Drives the instruction address (pc) and instruction-memory chip enable (ce).
- Over the basic PC register it adds:
  - configurable reset vector, address width and instruction size;
  - pipeline stall;
  - trap redirect with priority over branch;
  - capture of redirects that arrive while stalled;
  - target alignment with a misalignment flag;
  - a one-cycle flush pulse for the IF/ID register.

Parameters:
- ADDR_W, 32, width of pc and all target addresses.
- RESET_VEC, 32'h00000000, pc value on reset and while ce is disabled.
- INST_BYTES, 4, sequential increment in bytes. Legal values: 2 or 4. ALIGN_B = log2(INST_BYTES).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge).
- stall_i  in  1  hold pc (from hazard unit / memory not ready).
- branch_flag_i  in  1  branch/jump taken (from ID).
- branch_addr_i  in  ADDR_W  branch target.
- trap_flag_i  in  1  exception/interrupt redirect.
- trap_addr_i  in  ADDR_W  trap vector.
- pc  out  ADDR_W  fetch address.
- ce  out  1  instruction memory enable.
- flush_o  out  1  one-cycle pulse; pc was loaded from a redirect this edge.
- misalign_o  out  1  one-cycle pulse; the applied target had nonzero low ALIGN_B bits.

Behaviour:
- Reset (rst==0 at a clock edge) sets:
  - ce=0, pc=RESET_VEC, flush_o=0, misalign_o=0;
  - pending valid=0, pending kind=branch, pending addr=0.
  - Reset mid-operation discards any pending redirect.
- Boot sequence:
  - First edge with rst==1: ce<=1, pc stays RESET_VEC.
  - Second edge: pc<=RESET_VEC+INST_BYTES, unless stall or redirect applies.
- While ce==0:
  - pc held at RESET_VEC.
  - All redirect and stall inputs are ignored; nothing is captured.
- Live redirect source per cycle: trap_flag_i beats branch_flag_i.
- Next-pc priority when ce==1:
  1. stall_i==1: pc held; the redirect is captured (see below); flush_o=0.
  2. Live trap.
  3. Live branch.
  4. Pending redirect (pending valid==1).
  5. Sequential: pc+INST_BYTES, modulo 2^ADDR_W. 0xFFFFFFFC+4 wraps to 0.
- Capture while stalled:
  - A live trap always overwrites the pending entry.
  - A live branch writes the pending entry only if the entry is empty or holds a branch.
  - A branch never overwrites a pending trap.
  - Several redirects during one stall: the last one of the highest kind is kept.
- Stall release:
  - On the first non-stalled edge, pending valid is cleared whether it was used or not.
  - A live redirect in that same cycle wins over the pending one.
- Target alignment:
  - Every applied target (live or pending) has its low ALIGN_B bits forced to 0.
  - misalign_o=1 on the same edge if those bits were nonzero.
  - For a captured redirect, misalign_o pulses when it is applied, not when it is captured.
- flush_o=1 for exactly the cycle after an edge where pc was loaded from a live or pending redirect; otherwise 0.
- State encoding (implementation must match):
  - BOOT: ce=0.
  - RUN: ce=1, no pending.
  - HOLD_PEND: ce=1, pending valid.
- Transitions:
  - BOOT -> RUN on rst==1.
  - RUN -> HOLD_PEND on stall with a redirect.
  - HOLD_PEND -> RUN on stall release.
  - Any state -> BOOT on rst==0.
- Latency: redirect-to-pc is 1 cycle when not stalled; when stalled it takes effect 1 cycle after release.

Test Plan:
- Reset then release, no stall -> ce 0->1 one edge later. pc sequence: RESET_VEC, RESET_VEC, +4, +8 (RESET_VEC=0x80000000 gives 0x80000000, 0x80000000, 0x80000004, 0x80000008).
- branch_flag_i=1 and trap_flag_i=1 in the same cycle (branch 0x100, trap 0x200) -> pc=0x200, flush_o=1 for one cycle, misalign_o=0.
- stall_i high 3 cycles:
  - branch 0x40 in cycle 1, trap 0x300 in cycle 2, branch 0x80 in cycle 3;
  - expected: pc held, then 0x300 after release, pending cleared, next pc 0x304.
- Stall with pending branch 0x40, release in the same cycle as live branch 0x90 -> pc=0x90; next pc 0x94 (pending not applied later).
- branch_addr_i=0x00000106 with INST_BYTES=4 -> pc=0x00000104, misalign_o=1 for one cycle. pc=0xFFFFFFFC sequential -> pc=0x00000000.
- rst=0 asserted while HOLD_PEND with a trap pending -> pc=RESET_VEC, ce=0. After release there is no redirect and no flush_o pulse.

Source files
------------

// File: rtl/pc_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : pc_gen
//  Description : Program-counter generator for the in-order RISC-V fetch
//                stage. It sequences the fetch address, stalls, and redirects
//                on traps and branches. A trap beats a branch. A redirect seen
//                while stalled is held and applied once the stall releases.
//                Every applied target is forced to instruction alignment, and
//                a misalignment flag reports when that changed the address.
//                A one-cycle flush pulse marks each redirect for IF/ID.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
//  Ports
//    clk           in   1       clock, rising edge
//    rst           in   1       synchronous reset, active low
//    stall_i       in   1       hold pc (hazard unit / memory not ready)
//    branch_flag_i in   1       branch/jump taken
//    branch_addr_i in   ADDR_W  branch target
//    trap_flag_i   in   1       exception/interrupt redirect
//    trap_addr_i   in   ADDR_W  trap vector
//    pc            out  ADDR_W  fetch address
//    ce            out  1       instruction memory enable
//    flush_o       out  1       pc was loaded from a redirect on the last edge
//    misalign_o    out  1       that redirect target had nonzero low bits
//------------------------------------------------------------------------------
module pc_gen #(
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
   parameter int unsigned       INST_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_addr_i,
   input  logic              trap_flag_i,
   input  logic [ADDR_W-1:0] trap_addr_i,
   output logic [ADDR_W-1:0] pc,
   output logic              ce,
   output logic              flush_o,
   output logic              misalign_o
);

   // INST_BYTES is 2 or 4, so the number of alignment bits is 1 or 2.
   localparam int unsigned       c_ALIGN_B = (INST_BYTES == 2) ? 1 : 2;
   localparam logic [ADDR_W-1:0] c_INC     = ADDR_W'(INST_BYTES);

   // BOOT keeps memory disabled. RUN fetches with no pending entry.
   // HOLD_PEND fetches with a captured redirect waiting for stall release.
   localparam logic [1:0] c_ST_BOOT = 2'd0;
   localparam logic [1:0] c_ST_RUN  = 2'd1;
   localparam logic [1:0] c_ST_HOLD = 2'd2;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              r_flush;
   logic              r_misalign;
   logic              r_pend_trap;   // pending kind: 1 = trap, 0 = branch
   logic [ADDR_W-1:0] r_pend_addr;   // raw, unaligned target

   logic              w_pend_valid;
   logic              w_live_valid;
   logic [ADDR_W-1:0] w_live_addr;
   logic              w_capture;
   logic              w_tgt_valid;
   logic [ADDR_W-1:0] w_tgt_addr;
   logic [ADDR_W-1:0] w_tgt_aligned;
   logic              w_tgt_misalign;
   logic [ADDR_W-1:0] w_pc_seq;

   always_comb begin
      w_pend_valid = (r_state == c_ST_HOLD);

      // The live redirect source for this cycle: trap first, then branch.
      w_live_valid = trap_flag_i | branch_flag_i;
      w_live_addr  = trap_flag_i ? trap_addr_i : branch_addr_i;

      // A trap always takes the pending entry. A branch takes it only when
      // the entry is free or already holds a branch, so a held trap is kept.
      w_capture = trap_flag_i |
                  (branch_flag_i & (~w_pend_valid | ~r_pend_trap));

      // On a non-stalled edge a live redirect beats the pending one.
      w_tgt_valid = w_live_valid | w_pend_valid;
      w_tgt_addr  = w_live_valid ? w_live_addr : r_pend_addr;

      w_tgt_aligned  = {w_tgt_addr[ADDR_W-1:c_ALIGN_B], {c_ALIGN_B{1'b0}}};
      w_tgt_misalign = |w_tgt_addr[c_ALIGN_B-1:0];

      // Sequential fetch wraps modulo 2^ADDR_W.
      w_pc_seq = r_pc + c_INC;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= c_ST_BOOT;
         r_pc        <= RESET_VEC;
         r_flush     <= 1'b0;
         r_misalign  <= 1'b0;
         r_pend_trap <= 1'b0;
         r_pend_addr <= '0;
      end else begin
         case (r_state)
            c_ST_BOOT: begin
               // The first edge out of reset enables memory and keeps the
               // reset vector. Redirect and stall inputs are ignored here.
               r_state    <= c_ST_RUN;
               r_pc       <= RESET_VEC;
               r_flush    <= 1'b0;
               r_misalign <= 1'b0;
            end

            c_ST_RUN, c_ST_HOLD: begin
               if (stall_i) begin
                  r_flush    <= 1'b0;
                  r_misalign <= 1'b0;
                  if (w_capture) begin
                     r_pend_trap <= trap_flag_i;
                     r_pend_addr <= w_live_addr;
                     r_state     <= c_ST_HOLD;
                  end
               end else begin
                  // The release edge always empties the pending entry,
                  // whether or not it was the target that got applied.
                  r_state <= c_ST_RUN;
                  if (w_tgt_valid) begin
                     r_pc       <= w_tgt_aligned;
                     r_flush    <= 1'b1;
                     r_misalign <= w_tgt_misalign;
                  end else begin
                     r_pc       <= w_pc_seq;
                     r_flush    <= 1'b0;
                     r_misalign <= 1'b0;
                  end
               end
            end

            default: begin
               // Unreachable encoding: fall back to the boot state.
               r_state    <= c_ST_BOOT;
               r_pc       <= RESET_VEC;
               r_flush    <= 1'b0;
               r_misalign <= 1'b0;
            end
         endcase
      end
   end

   assign pc         = r_pc;
   assign ce         = (r_state != c_ST_BOOT);
   assign flush_o    = r_flush;
   assign misalign_o = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen. It runs directed scenarios
//                first and then random traffic. Every edge is checked against
//                a reference model written as plain rules.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pc_gen;

   localparam int unsigned c_AW  = 32;
   localparam logic [31:0] c_RV  = 32'h8000_0000;
   localparam int unsigned c_IB  = 4;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_addr_i;
   logic        trap_flag_i;
   logic [31:0] trap_addr_i;
   logic [31:0] pc;
   logic        ce;
   logic        flush_o;
   logic        misalign_o;

   pc_gen #(
      .ADDR_W     (c_AW),
      .RESET_VEC  (c_RV),
      .INST_BYTES (c_IB)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .branch_flag_i (branch_flag_i),
      .branch_addr_i (branch_addr_i),
      .trap_flag_i   (trap_flag_i),
      .trap_addr_i   (trap_addr_i),
      .pc            (pc),
      .ce            (ce),
      .flush_o       (flush_o),
      .misalign_o    (misalign_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state.
   bit          m_ce;
   logic [31:0] m_pc;
   bit          m_flush;
   bit          m_mis;
   bit          m_pv;       // a redirect is held
   bit          m_pk_trap;  // the held redirect is a trap
   logic [31:0] m_pa;

   // Apply the edge rules to the model.
   task automatic model_edge(input bit r, input bit s, input bit bf,
                             input logic [31:0] ba, input bit tf,
                             input logic [31:0] ta);
      logic [31:0] tgt;
      bit          have;
      if (!r) begin
         m_ce = 0; m_pc = c_RV; m_flush = 0; m_mis = 0;
         m_pv = 0; m_pk_trap = 0; m_pa = 0;
      end else if (!m_ce) begin
         m_ce = 1; m_pc = c_RV; m_flush = 0; m_mis = 0;
      end else if (s) begin
         m_flush = 0; m_mis = 0;
         if (tf) begin
            m_pv = 1; m_pk_trap = 1; m_pa = ta;
         end else if (bf && (!m_pv || !m_pk_trap)) begin
            m_pv = 1; m_pk_trap = 0; m_pa = ba;
         end
      end else begin
         have = 1;
         if (tf)        tgt = ta;
         else if (bf)   tgt = ba;
         else if (m_pv) tgt = m_pa;
         else begin have = 0; tgt = 0; end
         if (have) begin
            m_pc    = tgt - (tgt % c_IB);
            m_mis   = (tgt % c_IB) != 0;
            m_flush = 1;
         end else begin
            m_pc    = m_pc + c_IB;
            m_flush = 0;
            m_mis   = 0;
         end
         m_pv = 0;
      end
   endtask

   // Drive one cycle of inputs, take the edge, and compare with the model.
   task automatic cyc(input bit r, input bit s, input bit bf,
                      input logic [31:0] ba, input bit tf,
                      input logic [31:0] ta);
      rst = r; stall_i = s; branch_flag_i = bf; branch_addr_i = ba;
      trap_flag_i = tf; trap_addr_i = ta;
      @(posedge clk);
      model_edge(r, s, bf, ba, tf, ta);
      #1;
      check_val("pc",       pc,                 m_pc);
      check_val("ce",       {31'd0, ce},         {31'd0, m_ce});
      check_val("flush",    {31'd0, flush_o},    {31'd0, m_flush});
      check_val("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
   endtask

   task automatic idle();
      cyc(1, 0, 0, 32'h0, 0, 32'h0);
   endtask

   logic [31:0] held_pc;

   initial begin
      rst = 0; stall_i = 0; branch_flag_i = 0; branch_addr_i = 0;
      trap_flag_i = 0; trap_addr_i = 0;

      // Reset, then boot.
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h44, 1, 32'h88);
      check_val("rst_ce", {31'd0, ce}, 32'd0);
      check_val("rst_pc", pc, 32'h8000_0000);
      cyc(1, 0, 1, 32'h1234, 1, 32'h5678);   // redirect ignored while ce==0
      check_val("boot_ce", {31'd0, ce}, 32'd1);
      check_val("boot_pc", pc, 32'h8000_0000);
      idle();
      check_val("seq1_pc", pc, 32'h8000_0004);
      idle();
      check_val("seq2_pc", pc, 32'h8000_0008);

      // A trap and a branch in the same cycle: the trap wins.
      cyc(1, 0, 1, 32'h100, 1, 32'h200);
      check_val("prio_pc", pc, 32'h200);
      check_val("prio_flush", {31'd0, flush_o}, 32'd1);
      check_val("prio_mis", {31'd0, misalign_o}, 32'd0);
      idle();
      check_val("prio_flush_end", {31'd0, flush_o}, 32'd0);

      // Several redirects during a stall: the trap is kept.
      held_pc = m_pc;
      cyc(1, 1, 1, 32'h40, 0, 0);
      cyc(1, 1, 0, 0, 1, 32'h300);
      cyc(1, 1, 1, 32'h80, 0, 0);
      check_val("stall_hold_pc", pc, held_pc);
      idle();
      check_val("release_pc", pc, 32'h300);
      check_val("release_flush", {31'd0, flush_o}, 32'd1);
      idle();
      check_val("after_release_pc", pc, 32'h304);

      // A live branch on the release edge beats the pending branch.
      cyc(1, 1, 1, 32'h40, 0, 0);
      cyc(1, 0, 1, 32'h90, 0, 0);
      check_val("live_over_pend_pc", pc, 32'h90);
      idle();
      check_val("pend_dropped_pc", pc, 32'h94);

      // A misaligned target is aligned and flagged, and pc wraps at the top.
      cyc(1, 0, 1, 32'h106, 0, 0);
      check_val("align_pc", pc, 32'h104);
      check_val("align_mis", {31'd0, misalign_o}, 32'd1);
      idle();
      check_val("align_mis_end", {31'd0, misalign_o}, 32'd0);
      cyc(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
      idle();
      check_val("wrap_pc", pc, 32'h0);

      // Reset while a trap is pending discards it.
      cyc(1, 1, 0, 0, 1, 32'h500);
      cyc(0, 1, 0, 0, 0, 0);
      check_val("rst_pend_ce", {31'd0, ce}, 32'd0);
      check_val("rst_pend_pc", pc, 32'h8000_0000);
      idle();
      check_val("rst_pend_flush", {31'd0, flush_o}, 32'd0);
      idle();
      check_val("rst_pend_seq", pc, 32'h8000_0004);
      check_val("rst_pend_flush2", {31'd0, flush_o}, 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bit          r, s, bf, tf;
         logic [31:0] ba, ta;
         r  = ($urandom_range(0, 63) != 0);
         s  = ($urandom_range(0, 2) == 0);
         bf = ($urandom_range(0, 3) == 0);
         tf = ($urandom_range(0, 7) == 0);
         ba = $urandom;
         ta = $urandom;
         if ($urandom_range(0, 15) == 0) ba = 32'hFFFF_FFFC;
         if ($urandom_range(0, 1) == 0)  ta = {ta[31:2], 2'b00};
         cyc(r, s, bf, ba, tf, ta);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
